step_button_conditioner: RTL
============================

// Module: step_button_conditioner
// PURPOSE
//  Conditions the two raw board pushbuttons that drive manual clock stepping.
//  Each button is synchronised to i_SYS_CLOCK, debounced by a per-channel FSM, and turned into clean control signals.
//  These signals are the step-toggle pulse, the manual-mode level and the step-clock level.
//  The block sits directly upstream of the clock generator and feeds its step-toggle and step-clock inputs.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  consecutive stable synced samples needed to accept a press or release (>=2)
//  PULSE_CYCLES     4        width of o_STEP_TOGGLE pulse in clocks; legal range 1..DEBOUNCE_CYCLES
//  BTN_ACTIVE_LOW   0        1 = raw buttons read 0 when pressed; inverted at the input
// PORTS
//  i_SYS_CLOCK    in   1  system clock, all state on rising edge
//  i_RESET_n      in   1  asynchronous, active-low reset
//  i_BTN_TOGGLE   in   1  raw, asynchronous manual-mode toggle button
//  i_BTN_STEP     in   1  raw, asynchronous single-step button
//  o_STEP_TOGGLE  out  1  PULSE_CYCLES-wide high pulse per accepted toggle press
//  o_MANUAL_MODE  out  1  current manual-stepping mode; flips once per accepted toggle press
//  o_STEP_CLOCK   out  1  debounced step level: high while step press accepted and mode armed
// BEHAVIOUR
//  Reset (i_RESET_n=0, async assert, sync-released on next edge) sets every output to 0.
//   It also clears all sync flops and counters, and puts both FSMs in IDLE.
//   A reset mid-press or mid-pulse truncates the pulse immediately; no event is replayed.
//  Input path: optional inversion, then a 2-flop synchroniser per button. Only the 2nd flop feeds the FSM.
//  Per-channel FSM; count is a $clog2(DEBOUNCE_CYCLES+1)-bit counter, saturating, never wraps:
//   IDLE        : synced=1 -> PRESS_WAIT, count=1
//   PRESS_WAIT  : synced=1 -> count+1; synced=0 -> IDLE, count=0
//                 when count reaches DEBOUNCE_CYCLES -> PRESSED, press event (1 clk)
//   PRESSED     : synced=0 -> RELEASE_WAIT, count=1
//   RELEASE_WAIT: synced=0 -> count+1; synced=1 -> PRESSED, count=0, no new event
//                 when count reaches DEBOUNCE_CYCLES -> IDLE, release event (1 clk)
//  Latency: a clean raw press sampled at edge 0 gives the press event on edge 2+DEBOUNCE_CYCLES.
//   Outputs are registered and change on that same edge. Releases have the same latency.
//  Glitches shorter than DEBOUNCE_CYCLES produce no event in either direction.
//  Toggle channel, on press event:
//   - o_MANUAL_MODE inverts.
//   - o_STEP_TOGGLE goes high for exactly PULSE_CYCLES clocks (down-counter).
//   - Release events have no effect.
//   - Back-to-back presses are at least 2*DEBOUNCE_CYCLES apart, so pulses never overlap.
//  Step channel:
//   - armed flag: set by a step press event while o_MANUAL_MODE=1.
//   - armed flag: cleared by a step release event or when o_MANUAL_MODE=0.
//   - o_STEP_CLOCK = armed, registered.
//   - Mode entered while step already PRESSED: o_STEP_CLOCK stays 0 until release and a fresh press.
//     This prevents a spurious edge.
//   - Mode left while o_STEP_CLOCK=1: o_STEP_CLOCK drops on the same edge o_MANUAL_MODE drops.
//   - Simultaneous toggle and step press events on one edge: toggle applies first.
//     Step arms only if the new mode is 1.
//  Channels are otherwise independent; both buttons may be held simultaneously.
// TESTING (bench with DEBOUNCE_CYCLES=8, PULSE_CYCLES=4)
//  1. Reset, hold toggle 20 clks -> o_STEP_TOGGLE high edges 10..13 only; o_MANUAL_MODE=1 from edge 10.
//  2. Toggle bounce 1,0,1,0 each 3 clks, then stable 0 -> no pulse, o_MANUAL_MODE unchanged.
//  3. Mode=1, press step 12 clks, release -> o_STEP_CLOCK 1 from edge 10, 0 at 10 edges after release.
//  4. Mode=0, hold step, toggle mode on -> o_STEP_CLOCK stays 0; after release+re-press it rises.
//  5. o_STEP_CLOCK=1, toggle press -> o_MANUAL_MODE and o_STEP_CLOCK both fall on the same edge.
//  6. Assert i_RESET_n=0 mid-pulse (pulse clk 2) -> all outputs 0 immediately; no pulse after release.

Source files
------------

// File: rtl/step_button_conditioner.sv
// Step-button conditioner: synchronises and debounces the two manual-stepping
// pushbuttons and turns them into the step-toggle pulse, the manual-mode level
// and the step-clock level consumed by the clock generator.

// Per-channel debouncer. It emits a one-clock accepted-transition strobe (evt)
// and the debounced level (held). evt and held together give the direction:
// evt with held=1 is an accepted press, evt with held=0 is an accepted release.
module step_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic synced,
  output logic evt,
  output logic held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;

  // The stability counter saturates at DEBOUNCE_CYCLES so it can never wrap.
  assign count_inc = (count == CNT_MAX) ? count : count + CNT_ONE;

  // After an accepted press the FSM sits in PRESSED or RELEASE_WAIT.
  assign held = (state == PRESSED) || (state == RELEASE_WAIT);

  // Debounce FSM; evt is registered and lands on the same edge as the new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      evt   <= 1'b0;
    end else begin
      evt <= 1'b0;
      case (state)
        IDLE: begin
          if (synced) begin
            state <= PRESS_WAIT;
            count <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!synced) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count_inc;
            if (count_inc == CNT_MAX) begin
              state <= PRESSED;
              evt   <= 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!synced) begin
            state <= RELEASE_WAIT;
            count <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (synced) begin
            // Bounce back to pressed: no new press is reported.
            state <= PRESSED;
            count <= '0;
          end else begin
            count <= count_inc;
            if (count_inc == CNT_MAX) begin
              state <= IDLE;
              evt   <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

module step_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 4,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic i_SYS_CLOCK,
  input  logic i_RESET_n,
  input  logic i_BTN_TOGGLE,
  input  logic i_BTN_STEP,
  output logic o_STEP_TOGGLE,
  output logic o_MANUAL_MODE,
  output logic o_STEP_CLOCK
);

  localparam int PULSE_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(PULSE_CYCLES - 1);
  localparam logic [PULSE_W-1:0] PULSE_ONE  = PULSE_W'(1);

  logic               tgl_raw;
  logic               step_raw;
  logic               tgl_sync_p0;
  logic               tgl_sync_p1;
  logic               step_sync_p0;
  logic               step_sync_p1;
  logic               tgl_evt;
  logic               tgl_held;
  logic               step_evt;
  logic               step_held;
  logic               tgl_press;
  logic               step_press;
  logic               step_release;
  logic               mode_next;
  logic [PULSE_W-1:0] pulse_cnt;

  // Normalise polarity so that 1 always means "pressed" downstream.
  assign tgl_raw  = i_BTN_TOGGLE ^ BTN_ACTIVE_LOW;
  assign step_raw = i_BTN_STEP ^ BTN_ACTIVE_LOW;

  // Two-flop synchronisers; only the second flop is seen by the debouncers.
  always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      tgl_sync_p0  <= 1'b0;
      tgl_sync_p1  <= 1'b0;
      step_sync_p0 <= 1'b0;
      step_sync_p1 <= 1'b0;
    end else begin
      tgl_sync_p0  <= tgl_raw;
      tgl_sync_p1  <= tgl_sync_p0;
      step_sync_p0 <= step_raw;
      step_sync_p1 <= step_sync_p0;
    end
  end

  step_button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_tgl_db (
    .clk   (i_SYS_CLOCK),
    .rst_n (i_RESET_n),
    .synced(tgl_sync_p1),
    .evt   (tgl_evt),
    .held  (tgl_held)
  );

  step_button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk   (i_SYS_CLOCK),
    .rst_n (i_RESET_n),
    .synced(step_sync_p1),
    .evt   (step_evt),
    .held  (step_held)
  );

  // Toggle releases are deliberately ignored; only accepted presses matter.
  assign tgl_press    = tgl_evt & tgl_held;
  assign step_press   = step_evt & step_held;
  assign step_release = step_evt & ~step_held;

  // The toggle is applied before the step channel looks at the mode, so a
  // simultaneous step press arms only if the new mode is manual.
  assign mode_next = tgl_press ? ~o_MANUAL_MODE : o_MANUAL_MODE;

  // Manual-mode level and the fixed-width step-toggle pulse.
  always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      o_MANUAL_MODE <= 1'b0;
      o_STEP_TOGGLE <= 1'b0;
      pulse_cnt     <= '0;
    end else begin
      o_MANUAL_MODE <= mode_next;
      if (tgl_press) begin
        o_STEP_TOGGLE <= 1'b1;
        pulse_cnt     <= PULSE_LOAD;
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - PULSE_ONE;
      end else begin
        o_STEP_TOGGLE <= 1'b0;
      end
    end
  end

  // Step clock is armed only by a fresh press in manual mode, so entering
  // manual mode with the button already held never produces an edge.
  always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      o_STEP_CLOCK <= 1'b0;
    end else if (!mode_next || step_release) begin
      o_STEP_CLOCK <= 1'b0;
    end else if (step_press) begin
      o_STEP_CLOCK <= 1'b1;
    end
  end

endmodule
